// File: rtl/spi_tx.sv
// Dual-lane SPI master transmitter: one 2-lane AXI-Stream word becomes one CS-low frame,
// both lanes shifted MSB-first in parallel; CPOL=1, data stable across every SCLK rising edge.
module spi_tx #(
  parameter int DATA_LENGTH  = 12,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_ZEROS   = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [2*DATA_LENGTH-1:0]   s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [7:0]                 i_clkDiv,
  output logic                       o_cs,
  output logic                       o_sclk,
  output logic [1:0]                 o_data,
  output logic                       o_busy,
  output logic                       o_frameDone
);

  localparam int TAIL = FRAME_BITS - LEAD_ZEROS - DATA_LENGTH;
  localparam int RW   = $clog2(FRAME_BITS + 1);
  localparam int QW   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [RW-1:0]         rise_q, rise_d;
  logic [QW-1:0]         qcnt_q, qcnt_d;
  logic [FRAME_BITS-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_LENGTH-1:0] s);
    return FRAME_BITS'(s) << TAIL;
  endfunction

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    rise_d   = rise_q;
    qcnt_d   = qcnt_q;
    sr0_d    = sr0_q;
    sr1_d    = sr1_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    tready_d = tready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tready_d = 1'b1;
        busy_d   = 1'b0;
        if (s_axis_tvalid && tready_q) begin
          div_d    = (i_clkDiv == 8'd0) ? 8'd1 : i_clkDiv;
          sr0_d    = frame_of(s_axis_tdata[DATA_LENGTH-1:0]);
          sr1_d    = frame_of(s_axis_tdata[2*DATA_LENGTH-1:DATA_LENGTH]);
          cnt_d    = 8'd1;
          rise_d   = '0;
          cs_d     = 1'b0;
          sclk_d   = 1'b1;
          tready_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d = 8'd1;
          if (sclk_q) begin
            // The trailing high half-period after the last rising edge closes the frame.
            if (rise_q == RW'(FRAME_BITS)) begin
              cs_d   = 1'b1;
              done_d = 1'b1;
              sr0_d  = '0;
              sr1_d  = '0;
              qcnt_d = QW'(1);
              if (QUIET_CYCLES == 0) begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tready_d = 1'b1;
              end else begin
                state_d = QUIET;
              end
            end else begin
              sclk_d = 1'b0;
              if (rise_q != '0) begin
                sr0_d = {sr0_q[FRAME_BITS-2:0], 1'b0};
                sr1_d = {sr1_q[FRAME_BITS-2:0], 1'b0};
              end
            end
          end else begin
            sclk_d = 1'b1;
            rise_d = rise_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      QUIET: begin
        if (qcnt_q >= QW'(QUIET_CYCLES)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          tready_d = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      div_q    <= 8'd1;
      cnt_q    <= 8'd1;
      rise_q   <= '0;
      qcnt_q   <= '0;
      sr0_q    <= '0;
      sr1_q    <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      qcnt_q   <= qcnt_d;
      sr0_q    <= sr0_d;
      sr1_q    <= sr1_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_cs          = cs_q;
  assign o_sclk        = sclk_q;
  assign o_data        = {sr1_q[FRAME_BITS-1], sr0_q[FRAME_BITS-1]};
  assign o_busy        = busy_q;
  assign o_frameDone   = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: a negedge monitor reconstructs each frame from the pins and the tests
// compare it with the expected frame built from the word by plain bit arithmetic.
module tb_spi_tx;
  localparam int DL = 12;
  localparam int FB = 16;
  localparam int LZ = 2;
  localparam int QC = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  i_clkDiv = 8'd1;
  logic        o_cs, o_sclk, o_busy, o_frameDone;
  logic [1:0]  o_data;

  int n_tests = 0;
  int n_fail  = 0;

  spi_tx #(.DATA_LENGTH(DL), .FRAME_BITS(FB), .LEAD_ZEROS(LZ), .QUIET_CYCLES(QC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .i_clkDiv(i_clkDiv), .o_cs(o_cs), .o_sclk(o_sclk),
    .o_data(o_data), .o_busy(o_busy), .o_frameDone(o_frameDone)
  );

  always #5 i_clk = ~i_clk;

  // Pin monitor: in-frame accumulators plus the record of the last completed frame.
  int          cs_low_cnt = 0, rise_n = 0, first_fall = 0, run_len = 0, min_run = 0, max_run = 0;
  int          high_run = 0, last_gap = 0;
  int          frames_cnt = 0, done_cnt = 0, done_bad = 0, idle_bad = 0;
  int          f_len = 0, f_rises = 0, f_first_fall = 0, f_min = 0, f_max = 0;
  logic [15:0] bits0 = '0, bits1 = '0, f_b0 = '0, f_b1 = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      high_run  = 0;
    end else begin
      if (o_frameDone) begin
        done_cnt++;
        if (!(o_cs && !prev_cs)) done_bad++;
      end
      if (!o_cs) begin
        if (prev_cs) begin
          last_gap   = high_run;
          cs_low_cnt = 0;
          rise_n     = 0;
          bits0      = '0;
          bits1      = '0;
          first_fall = 0;
          run_len    = 1;
          min_run    = 1000000;
          max_run    = 0;
        end else if (o_sclk == prev_sclk) begin
          run_len++;
        end else begin
          if (run_len < min_run) min_run = run_len;
          if (run_len > max_run) max_run = run_len;
          run_len = 1;
          if (o_sclk) begin
            rise_n++;
            bits0 = {bits0[14:0], o_data[0]};
            bits1 = {bits1[14:0], o_data[1]};
          end
        end
        cs_low_cnt++;
        if (!o_sclk && first_fall == 0) first_fall = cs_low_cnt;
        high_run = 0;
      end else begin
        if (!prev_cs) begin
          if (run_len < min_run) min_run = run_len;
          if (run_len > max_run) max_run = run_len;
          f_len = cs_low_cnt; f_rises = rise_n; f_b0 = bits0; f_b1 = bits1;
          f_first_fall = first_fall; f_min = min_run; f_max = max_run;
          frames_cnt++;
        end
        if (o_sclk !== 1'b1 || o_data !== 2'b00) idle_bad++;
        high_run++;
      end
      prev_cs   = o_cs;
      prev_sclk = o_sclk;
    end
  end

  // Bit k of the frame (k-th rising edge) lands at position FB-1-k, matching the monitor's shift-in.
  function automatic logic [15:0] exp_lane(input logic [11:0] s);
    logic [15:0] e = '0;
    for (int k = 0; k < FB; k++)
      if (k >= LZ && k < LZ + DL) e[FB-1-k] = s[DL-1-(k-LZ)];
    return e;
  endfunction

  task automatic send(input logic [23:0] w, input logic [7:0] div, input bit hold);
    int n = 0;
    @(negedge i_clk);
    s_axis_tdata  = w;
    i_clkDiv      = div;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake: tready=%b after %0d cycles, required 1", s_axis_tready, n);
      s_axis_tvalid = 1'b0;
    end else begin
      @(posedge i_clk);
      #1;
      if (!hold) s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_cnt < target && n < 5000) begin
      @(posedge i_clk);
      n++;
    end
    n_tests++;
    if (frames_cnt < target) begin
      n_fail++;
      $display("FAIL frame_timeout: frames=%0d required %0d", frames_cnt, target);
    end
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 24'($urandom());
    repeat (3) @(negedge i_clk);
    n_tests++;
    if ({o_cs, o_sclk, o_data, s_axis_tready, o_busy, o_frameDone} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_outputs: cs,sclk,data,tready,busy,done=%b required 1100000",
               {o_cs, o_sclk, o_data, s_axis_tready, o_busy, o_frameDone});
    end
    #1 i_rst = 1'b0;
    #1;
    n_tests++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL tready_at_release: got %b required 0", s_axis_tready);
    end
    @(posedge i_clk); #1;
    s_axis_tvalid = 1'b0;
    n_tests++;
    if (s_axis_tready !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tready_after_edge: tready=%b busy=%b required 1 0", s_axis_tready, o_busy);
    end
  endtask

  task automatic test_div1();
    int d0 = done_cnt;
    send(24'h123ABC, 8'd1, 1'b0);
    wait_frames(frames_cnt + 1);
    n_tests++;
    if (f_b0 !== 16'h2AF0 || f_b1 !== 16'h048C) begin
      n_fail++; $display("FAIL div1_bits: lane0=%h lane1=%h required 2af0 048c", f_b0, f_b1);
    end
    n_tests++;
    if (f_len !== 33 || f_rises !== 16) begin
      n_fail++; $display("FAIL div1_len: cs_low=%0d rises=%0d required 33 16", f_len, f_rises);
    end
    n_tests++;
    if (f_first_fall !== 2 || f_min !== 1 || f_max !== 1) begin
      n_fail++;
      $display("FAIL div1_sclk: first_fall=%0d min=%0d max=%0d required 2 1 1", f_first_fall, f_min, f_max);
    end
    n_tests++;
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL div1_done: pulses=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_div3();
    send(24'h123ABC, 8'd3, 1'b0);
    wait_frames(frames_cnt + 1);
    n_tests++;
    if (f_b0 !== exp_lane(12'hABC) || f_b1 !== exp_lane(12'h123)) begin
      n_fail++; $display("FAIL div3_bits: lane0=%h lane1=%h required %h %h", f_b0, f_b1,
                         exp_lane(12'hABC), exp_lane(12'h123));
    end
    n_tests++;
    if (f_len !== 99 || f_first_fall !== 4 || f_min !== 3 || f_max !== 3) begin
      n_fail++;
      $display("FAIL div3_timing: cs_low=%0d first_fall=%0d min=%0d max=%0d required 99 4 3 3",
               f_len, f_first_fall, f_min, f_max);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [23:0] w = 24'($urandom());
      logic [7:0]  div = 8'($urandom_range(0, 4));
      int          de = (div == 0) ? 1 : int'(div);
      send(w, div, 1'b0);
      wait_frames(frames_cnt + 1);
      n_tests++;
      if (f_b0 !== exp_lane(w[11:0]) || f_b1 !== exp_lane(w[23:12]) || f_len !== (2*FB+1)*de
          || f_rises !== FB) begin
        n_fail++;
        $display("FAIL random_%0d: w=%h div=%0d lane0=%h lane1=%h len=%0d rises=%0d required %h %h %0d %0d",
                 i, w, div, f_b0, f_b1, f_len, f_rises, exp_lane(w[11:0]), exp_lane(w[23:12]),
                 (2*FB+1)*de, FB);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w1 = 24'($urandom());
    logic [23:0] w2 = 24'($urandom());
    int f0 = frames_cnt;
    send(w1, 8'd1, 1'b1);
    send(w2, 8'd1, 1'b0);
    wait_frames(f0 + 1);
    n_tests++;
    if (f_b0 !== exp_lane(w1[11:0]) || f_b1 !== exp_lane(w1[23:12])) begin
      n_fail++; $display("FAIL b2b_first: lane0=%h lane1=%h required %h %h", f_b0, f_b1,
                         exp_lane(w1[11:0]), exp_lane(w1[23:12]));
    end
    wait_frames(f0 + 2);
    n_tests++;
    if (last_gap !== QC + 1) begin
      n_fail++; $display("FAIL b2b_gap: cs_high=%0d required %0d", last_gap, QC + 1);
    end
    n_tests++;
    if (f_b0 !== exp_lane(w2[11:0]) || f_b1 !== exp_lane(w2[23:12]) || f_len !== 33) begin
      n_fail++; $display("FAIL b2b_second: lane0=%h lane1=%h len=%0d required %h %h 33", f_b0, f_b1,
                         f_len, exp_lane(w2[11:0]), exp_lane(w2[23:12]));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] w2 = 24'($urandom());
    int f0 = frames_cnt;
    int d0 = done_cnt;
    int n = 0;
    send(24'($urandom()), 8'd1, 1'b0);
    while (rise_n < 7 && n < 500) begin
      @(posedge i_clk);
      n++;
    end
    n_tests++;
    if (rise_n < 7) begin
      n_fail++; $display("FAIL midrst_wait: rises=%0d required 7", rise_n);
    end
    #2 i_rst = 1'b1;
    #1;
    n_tests++;
    if ({o_cs, o_sclk, o_data, o_busy} !== 5'b11000) begin
      n_fail++; $display("FAIL midrst_abort: cs,sclk,data,busy=%b required 11000",
                         {o_cs, o_sclk, o_data, o_busy});
    end
    @(negedge i_clk);
    #1 i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    n_tests++;
    if (frames_cnt !== f0 || done_cnt !== d0) begin
      n_fail++; $display("FAIL midrst_nodone: frames=%0d done=%0d required %0d %0d",
                         frames_cnt, done_cnt, f0, d0);
    end
    send(w2, 8'd1, 1'b0);
    wait_frames(f0 + 1);
    n_tests++;
    if (f_b0 !== exp_lane(w2[11:0]) || f_b1 !== exp_lane(w2[23:12]) || f_len !== 33) begin
      n_fail++; $display("FAIL midrst_next: lane0=%h lane1=%h len=%0d required %h %h 33", f_b0, f_b1,
                         f_len, exp_lane(w2[11:0]), exp_lane(w2[23:12]));
    end
  endtask

  task automatic test_div_change();
    logic [23:0] w = 24'($urandom());
    int f0 = frames_cnt;
    send(w, 8'd1, 1'b0);
    repeat (6) @(posedge i_clk);
    #1 i_clkDiv = 8'd5;
    wait_frames(f0 + 1);
    n_tests++;
    if (f_len !== 33 || f_min !== 1 || f_max !== 1) begin
      n_fail++; $display("FAIL divchg_current: len=%0d min=%0d max=%0d required 33 1 1", f_len, f_min, f_max);
    end
    send(w, 8'd5, 1'b0);
    wait_frames(f0 + 2);
    n_tests++;
    if (f_len !== 165 || f_min !== 5 || f_max !== 5 || f_b0 !== exp_lane(w[11:0])) begin
      n_fail++; $display("FAIL divchg_div5: len=%0d min=%0d max=%0d lane0=%h required 165 5 5 %h",
                         f_len, f_min, f_max, f_b0, exp_lane(w[11:0]));
    end
    send(w, 8'd0, 1'b0);
    wait_frames(f0 + 3);
    n_tests++;
    if (f_len !== 33 || f_first_fall !== 2 || f_b1 !== exp_lane(w[23:12])) begin
      n_fail++; $display("FAIL divchg_div0: len=%0d first_fall=%0d lane1=%h required 33 2 %h",
                         f_len, f_first_fall, f_b1, exp_lane(w[23:12]));
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_div_change();
    repeat (10) @(posedge i_clk);
    n_tests++;
    if (done_bad !== 0 || idle_bad !== 0) begin
      n_fail++; $display("FAIL pin_invariants: stray_done=%0d idle_violations=%0d required 0 0",
                         done_bad, idle_bad);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
